// File: rtl/teclado_entrada_display.sv
// Keypad entry buffer: accepts each key press once, builds a 4-digit BCD value, scans a 4-digit 7-seg display.
// Latency: key effect after the accepting edge; enter commits one edge after enter_sync is registered. No backpressure.
module teclado_entrada_display #(
    parameter int REFRESH_DIV    = 4,
    parameter int RELEASE_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  digito,
    input  logic        cambio_digito,
    input  logic        enter_sync,
    output logic [3:0]  anodo,
    output logic [6:0]  seg,
    output logic [15:0] valor,
    output logic        valor_valid,
    output logic [2:0]  cant
);

    localparam int RW = $clog2(RELEASE_CYCLES + 1);
    localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic {LIBRE, PRESIONADA} estado_t;

    estado_t        estado, estado_sig;
    logic [RW-1:0]  rel_cnt;
    logic           acepta;
    logic           enter_q, enter_prev;
    logic           commit;
    logic [15:0]    buffer;
    logic [DW-1:0]  ref_cnt;
    logic [1:0]     idx;
    logic [3:0]     dig_act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado <= LIBRE;
        else        estado <= estado_sig;
    end

    always_comb begin
        estado_sig = estado;
        acepta     = 1'b0;
        case (estado)
            LIBRE: begin
                if (cambio_digito && digito <= 5'h0F) begin
                    acepta     = 1'b1;
                    estado_sig = PRESIONADA;
                end
            end
            PRESIONADA: begin
                if (!cambio_digito && rel_cnt == RW'(RELEASE_CYCLES - 1))
                    estado_sig = LIBRE;
            end
            default: estado_sig = LIBRE;
        endcase
    end

    // Release counter only runs while a press is held; any key activity restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rel_cnt <= '0;
        end else if (estado == PRESIONADA && !cambio_digito && estado_sig == PRESIONADA) begin
            rel_cnt <= rel_cnt + RW'(1);
        end else begin
            rel_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enter_q    <= 1'b0;
            enter_prev <= 1'b0;
        end else begin
            enter_q    <= enter_sync;
            enter_prev <= enter_q;
        end
    end

    assign commit = enter_q && !enter_prev && (cant != 3'd0);

    // A commit overrides any key accepted on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buffer      <= '0;
            cant        <= '0;
            valor       <= '0;
            valor_valid <= 1'b0;
        end else begin
            valor_valid <= 1'b0;
            if (commit) begin
                valor       <= buffer;
                valor_valid <= 1'b1;
                buffer      <= '0;
                cant        <= '0;
            end else if (acepta) begin
                if (digito[3:0] <= 4'd9) begin
                    if (cant < 3'd4) begin
                        buffer <= {buffer[11:0], digito[3:0]};
                        cant   <= cant + 3'd1;
                    end
                end else if (digito[3:0] == 4'hE) begin
                    buffer <= '0;
                    cant   <= '0;
                end else if (digito[3:0] == 4'hF) begin
                    if (cant != 3'd0) begin
                        buffer <= {4'h0, buffer[15:4]};
                        cant   <= cant - 3'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt <= '0;
            idx     <= '0;
        end else if (ref_cnt == DW'(REFRESH_DIV - 1)) begin
            ref_cnt <= '0;
            idx     <= idx + 2'd1;
        end else begin
            ref_cnt <= ref_cnt + DW'(1);
        end
    end

    assign anodo   = ~(4'b0001 << idx);
    assign dig_act = buffer[{idx, 2'b00} +: 4];

    always_comb begin
        seg = 7'h7F;
        if ({1'b0, idx} < cant) begin
            case (dig_act)
                4'd0:    seg = 7'h40;
                4'd1:    seg = 7'h79;
                4'd2:    seg = 7'h24;
                4'd3:    seg = 7'h30;
                4'd4:    seg = 7'h19;
                4'd5:    seg = 7'h12;
                4'd6:    seg = 7'h02;
                4'd7:    seg = 7'h78;
                4'd8:    seg = 7'h00;
                4'd9:    seg = 7'h10;
                default: seg = 7'h7F;
            endcase
        end
    end

endmodule

// File: tb/tb_teclado_entrada_display.sv
// Bench for teclado_entrada_display: table of key sequences, commit scoreboard, and hand-written timing cases.
module tb_teclado_entrada_display;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  digito = 5'd16;
    logic        cambio_digito = 1'b0;
    logic        enter_sync = 1'b0;
    logic [3:0]  anodo;
    logic [6:0]  seg;
    logic [15:0] valor;
    logic        valor_valid;
    logic [2:0]  cant;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    teclado_entrada_display #(.REFRESH_DIV(DIV), .RELEASE_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .digito(digito), .cambio_digito(cambio_digito),
        .enter_sync(enter_sync), .anodo(anodo), .seg(seg), .valor(valor),
        .valor_valid(valor_valid), .cant(cant)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              n;
        logic [5:0][4:0] keys;
        logic [2:0]      cant;
        logic [15:0]     buf_v;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;  default: return 7'h7F;
        endcase
    endfunction

    // Commit scoreboard: every valor_valid pulse must match the oldest expected commit.
    always @(negedge clk) begin
        if (rst_n && valor_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valor_valid", 1, 0);
            end else begin
                check("valor_commit", valor, exp_q.pop_front());
            end
        end
    end

    task automatic press(input logic [4:0] key, input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            digito        = key;
            cambio_digito = (i % 4 == 0);
        end
        @(negedge clk);
        cambio_digito = 1'b0;
        digito        = 5'd16;
        repeat (9) @(negedge clk);
    endtask

    task automatic do_enter();
        @(negedge clk);
        enter_sync = 1'b1;
        repeat (3) @(negedge clk);
        enter_sync = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_display(input logic [15:0] b, input logic [2:0] c);
        int k;
        logic [6:0] e;
        for (int i = 0; i < 4 * DIV; i++) begin
            @(negedge clk);
            case (anodo)
                4'b1110: k = 0;
                4'b1101: k = 1;
                4'b1011: k = 2;
                4'b0111: k = 3;
                default: k = -1;
            endcase
            if (k < 0) begin
                check("anodo_onehot", anodo, 4'b1110);
            end else begin
                e = (k < int'(c)) ? seg_of(b[k*4 +: 4]) : 7'h7F;
                check("seg_scan", seg, e);
            end
        end
    endtask

    initial begin
        logic [3:0] prev;
        int len;
        int guard;

        vecs[0] = '{n: 3, keys: {5'd0, 5'd0, 5'd0, 5'd3, 5'd2, 5'd1}, cant: 3'd3, buf_v: 16'h0123};
        vecs[1] = '{n: 5, keys: {5'd0, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, cant: 3'd4, buf_v: 16'h1234};
        vecs[2] = '{n: 6, keys: {5'hF, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, cant: 3'd3, buf_v: 16'h0123};
        vecs[3] = '{n: 1, keys: {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'hF}, cant: 3'd0, buf_v: 16'h0000};
        vecs[4] = '{n: 3, keys: {5'd0, 5'd0, 5'd0, 5'd6, 5'hE, 5'd8}, cant: 3'd1, buf_v: 16'h0006};
        vecs[5] = '{n: 4, keys: {5'd0, 5'd0, 5'hD, 5'd0, 5'hA, 5'd9}, cant: 3'd2, buf_v: 16'h0090};
        vecs[6] = '{n: 2, keys: {5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd17}, cant: 3'd1, buf_v: 16'h0003};
        vecs[7] = '{n: 2, keys: {5'd0, 5'd0, 5'd0, 5'd0, 5'd2, 5'd4}, cant: 3'd2, buf_v: 16'h0042};

        repeat (2) @(negedge clk);
        check("reset_anodo", anodo, 4'b1110);
        check("reset_seg", seg, 7'h7F);
        check("reset_cant", cant, 0);
        check("reset_valor", valor, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_cant", cant, 0);
        check("idle_seg", seg, 7'h7F);

        // Each display slot lasts exactly DIV cycles.
        for (int s = 0; s < 2; s++) begin
            prev = anodo;
            guard = 0;
            while (anodo == prev && guard < 4 * DIV + 2) begin
                @(negedge clk);
                guard++;
            end
            prev = anodo;
            len = 0;
            do begin
                @(negedge clk);
                len++;
            end while (anodo == prev && len < 20);
            check("slot_width", len, DIV);
        end

        for (int v = 0; v < 8; v++) begin
            press(5'hE, 12);
            for (int i = 0; i < vecs[v].n; i++) press(vecs[v].keys[i], 12);
            check($sformatf("vec%0d_cant", v), cant, vecs[v].cant);
            check_display(vecs[v].buf_v, vecs[v].cant);
            if (vecs[v].cant != 3'd0) begin
                exp_q.push_back(vecs[v].buf_v);
                do_enter();
                check($sformatf("vec%0d_cant_after_enter", v), cant, 0);
            end
        end

        // Enter timing: registered at N, committed at N+1.
        press(5'd4, 12);
        press(5'd2, 12);
        exp_q.push_back(16'h0042);
        @(negedge clk);
        enter_sync = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("enter_valor", valor, 16'h0042);
        check("enter_pulse", valor_valid, 1);
        check("enter_cant", cant, 0);
        @(posedge clk);
        #1;
        check("enter_pulse_width", valor_valid, 0);
        @(negedge clk);
        enter_sync = 1'b0;
        repeat (3) @(negedge clk);
        do_enter();
        check("empty_enter_valor", valor, 16'h0042);

        // Held key: only one append.
        press(5'd7, 40);
        check("hold_cant", cant, 1);
        check_display(16'h0007, 3'd1);

        // Key accepted on the enter-edge cycle is dropped in favour of the commit.
        press(5'hE, 12);
        press(5'd4, 12);
        press(5'd2, 12);
        exp_q.push_back(16'h0042);
        @(negedge clk);
        enter_sync = 1'b1;
        @(negedge clk);
        digito = 5'd5;
        cambio_digito = 1'b1;
        @(negedge clk);
        digito = 5'd16;
        cambio_digito = 1'b0;
        enter_sync = 1'b0;
        repeat (10) @(negedge clk);
        check("simul_cant", cant, 0);
        press(5'd6, 12);
        check("after_simul_cant", cant, 1);

        // Reset in the middle of a press.
        press(5'hE, 12);
        press(5'd1, 12);
        @(negedge clk);
        digito = 5'd2;
        cambio_digito = 1'b1;
        @(negedge clk);
        cambio_digito = 1'b0;
        check("midpress_cant", cant, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_cant", cant, 0);
        check("rst_seg", seg, 7'h7F);
        check("rst_anodo", anodo, 4'b1110);
        digito = 5'd16;
        @(negedge clk);
        rst_n = 1'b1;
        press(5'd9, 12);
        check("post_rst_cant", cant, 1);
        check_display(16'h0009, 3'd1);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/teclado_entrada_display.md
# teclado_entrada_display

Consumer side of the keypad scan interface. Takes the decoded key stream from the keypad driver (`digito`, `cambio_digito`, `enter_sync`) and turns it into a 4-digit BCD entry buffer. A press/release lock ensures each physical press is accepted exactly once. The block drives a multiplexed 4-digit 7-segment display and publishes the entered value on enter.

## Interface
Parameters:
- `REFRESH_DIV`, default 4: clock cycles per display digit slot (≥1).
- `RELEASE_CYCLES`, default 8: consecutive cycles with `cambio_digito`=0 needed to declare a key released (≥5, longer than one column scan period of 4 cycles).

Ports:
- `clk`  in  1  system clock, shared with the keypad driver.
- `rst_n`  in  1  asynchronous, active-low reset.
- `digito`  in  5  key code: 0–9 digits, 0xA–0xD unused, 0xE clear, 0xF delete, 16/17 no key or invalid.
- `cambio_digito`  in  1  high while the driver sees a key on the current column.
- `enter_sync`  in  1  synchronized enter button, level.
- `anodo`  out  4  digit select, active-low. Bit 0 is the rightmost digit.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `valor`  out  16  last committed value, 4 BCD digits; [3:0] is the least significant digit.
- `valor_valid`  out  1  one-cycle pulse when `valor` updates.
- `cant`  out  3  number of digits currently in the buffer, 0–4.

## Operation
- Key FSM has two states, LIBRE and PRESIONADA.
  - In LIBRE, `cambio_digito`=1 with `digito`≤0xF accepts the key and moves to PRESIONADA.
  - In LIBRE, `cambio_digito`=1 with codes 16 or 17 is ignored, and the FSM stays in LIBRE.
  - In PRESIONADA, a release counter clears on every cycle with `cambio_digito`=1 and increments otherwise. When it reaches `RELEASE_CYCLES`, the FSM returns to LIBRE and the counter clears.
  - Keys arriving in PRESIONADA are ignored.
- Accepted key effects:
  - Digit 0–9 with `cant`<4: buffer <= {buffer[11:0], digito[3:0]}, `cant`+1.
  - Digit 0–9 with `cant`=4: buffer full. The key is discarded, but the FSM still enters PRESIONADA.
  - 0xE: buffer <= 0, `cant` <= 0.
  - 0xF with `cant`>0: buffer <= {4'h0, buffer[15:4]}, `cant`−1.
  - 0xF with `cant`=0: no change.
  - 0xA–0xD: no buffer change. The FSM still enters PRESIONADA.
- Enter:
  - The block registers `enter_sync` and detects its rising edge.
  - On a rising edge with `cant`>0: `valor` <= buffer, `valor_valid`=1 for one cycle, buffer <= 0, `cant` <= 0.
  - On a rising edge with `cant`=0: ignored, no pulse.
- Simultaneous enter edge and key acceptance:
  - The enter action wins and the key's buffer effect is discarded.
  - The FSM still moves to PRESIONADA.
- Display multiplexing:
  - Refresh counter runs 0..`REFRESH_DIV`−1. At the terminal count, scan index `idx` advances 0→1→2→3→0.
  - `anodo` = ~(1<<idx).
  - `seg` shows the standard hex-free decode of buffer digit `idx` (0–9) when `idx`<`cant`; otherwise blank (7'h7F).
  - `anodo` and `seg` are combinational from `idx`, buffer and `cant`. All state is registered.

## Timing
- Reset (async assert, sync release) values:
  - FSM = LIBRE, counters 0, buffer 0, `cant`=0, `valor`=0, `valor_valid`=0, `idx`=0.
  - Resulting outputs: `anodo`=4'b1110, `seg`=7'h7F.
- Key latency: with `cambio_digito`=1 in LIBRE sampled at edge N, buffer and `cant` are updated after edge N.
- Enter latency: `enter_sync` rises before edge N and is registered at N. The rising edge is seen at N+1, where `valor` and `valor_valid` update. The pulse lasts exactly one cycle.
- A held key (pulsing 1 of every 4 cycles from the driver) never re-triggers. The release counter cannot reach `RELEASE_CYCLES`≥5 while the key is held.
- Digit slot width is exactly `REFRESH_DIV` cycles. A full display frame is 4·`REFRESH_DIV` cycles.
- Reset mid-press or mid-frame: everything returns to reset values immediately. Any in-progress press is dropped.

## Test plan
- Reset, then idle 20 cycles -> `anodo`=1110, `seg`=7F, `cant`=0, `valor_valid` never high.
- Press 1, 2, 3 (each press: `cambio_digito` 1 every 4th cycle for 12 cycles, then 0 for 10) -> `cant`=3; `seg` shows 3, 2, 1 on idx 0, 1, 2 and blank on idx 3.
- Press 1, 2, 3, 4, 5 -> buffer 0x1234, `cant`=4, the 5 is discarded. Then press 0xF -> 0x0123, `cant`=3.
- Buffer 0x0042, raise `enter_sync` -> after 2 edges `valor`=0x0042, one-cycle `valor_valid`, `cant`=0. A second enter edge with `cant`=0 -> no pulse.
- Hold digit 7 for 40 cycles -> exactly one digit appended. A key arriving on the same cycle as an enter edge -> commit only, key not appended.
- Assert `rst_n`=0 mid-press with `cant`=2 -> `cant`=0 and `seg`=7F immediately; the next press is accepted normally.
